// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, wait-state
// limits and the address fault check used at the response boundary.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // WAIT_CYCLES may range over 0..WAIT_MAX; the counter is sized to match.
  localparam int unsigned WAIT_MAX = 15;
  localparam int unsigned WCNT_W   = 4;

  // Byte address -> word index split and the alignment bits that must be zero.
  localparam int unsigned ADDR_LSB   = 2;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  function automatic logic addr_fault(input logic [31:0] addr, input logic [31:0] depth);
    logic [31:0] word_idx;
    word_idx = addr >> ADDR_LSB;
    return ((addr[1:0] & ALIGN_MASK) != 2'b00) || (word_idx >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte write enables and a registered read.
// Contents are never reset; a read on a write cycle returns the old word.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, then
// presents a single response held until the core consumes it.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output state_e      dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both 1; a response completes on a rising edge where
  // rsp_valid and rsp_ready are both 1. Neither side may retract valid.

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [WCNT_W-1:0] WCNT_LAST =
    NO_WAIT ? '0 : WCNT_W'(WAIT_CYCLES - 1);

  state_e            state;
  state_e            state_next;
  logic [WCNT_W-1:0] wcnt;
  logic              active;

  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;

  logic              accept;
  logic              enter_resp;
  logic              use_live;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_wstrb;
  logic              fault;
  logic              rd_sel;
  logic [31:0]       arr_rdata;

  // State register; active gates req_ready off until the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      wcnt   <= '0;
      active <= 1'b0;
    end else begin
      state  <= state_next;
      active <= 1'b1;
      wcnt   <= (state == ST_WAIT) ? wcnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = NO_WAIT ? ST_RESP : ST_WAIT;
      ST_WAIT: if (wcnt == WCNT_LAST) state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE) && active;
    rsp_valid = (state == ST_RESP);
    dbg_state = state;
  end

  assign accept     = req_ready && req_valid;
  assign enter_resp = (state_next == ST_RESP) && (state != ST_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
    end
  end

  // With zero wait states the access happens on the acceptance edge itself,
  // so the live request fields are used instead of the captured copies.
  assign use_live  = (state == ST_IDLE);
  assign cur_we    = use_live ? req_we    : we_q;
  assign cur_addr  = use_live ? req_addr  : addr_q;
  assign cur_wdata = use_live ? req_wdata : wdata_q;
  assign cur_wstrb = use_live ? req_wstrb : wstrb_q;
  assign fault     = addr_fault(cur_addr, DEPTH_WORDS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_err <= 1'b0;
      rd_sel  <= 1'b0;
    end else if (enter_resp) begin
      rsp_err <= fault;
      rd_sel  <= !fault && !cur_we;
    end else if ((state == ST_RESP) && rsp_ready) begin
      rsp_err <= 1'b0;
      rd_sel  <= 1'b0;
    end
  end

  // The array only fires on RESP entry, so its output register holds the
  // loaded word unchanged for the whole response.
  assign rsp_rdata = rd_sel ? arr_rdata : '0;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .en    (enter_resp && !fault),
    .we    (cur_we),
    .be    (cur_wstrb),
    .addr  (cur_addr[ADDR_LSB +: AW]),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for the main
// scenarios and a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dmem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  state_e      dbg_state;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_wstrb;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  state_e      b_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .dbg_state(b_dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          output logic ready_seen);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_wdata = wdata; req_wstrb = wstrb;
    ready_seen = req_ready;
    @(posedge clk); #1;
    // Scramble request fields after acceptance; the DUT must ignore them.
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        output logic ready_seen, output int lat,
                        output logic [31:0] rdata, output logic err);
    send_req(we, addr, wdata, wstrb, ready_seen);
    wait_rsp(lat);
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_tests++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
    n_tests++; if (b_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_b_req_ready: got %b want 0", b_req_ready); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    n_tests++; if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_b_ready: got %b want 1", b_req_ready); end
  endtask

  task automatic test_store_load();
    logic rdy, err; int lat; logic [31:0] rd;
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rdy, lat, rd, err);
    n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL sl_st_ready: got %b want 1", rdy); end
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL sl_st_latency: got %0d want 3", lat); end
    n_tests++; if (err !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL sl_st_rsp: got err=%b rdata=%h want err=0 rdata=0", err, rd); end
    finish_rsp();
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL sl_idle_after: got %b want 1", req_ready); end
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rdy, lat, rd, err);
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL sl_ld_latency: got %0d want 3", lat); end
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sl_ld_rdata: got %h want deadbeef", rd); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL sl_ld_err: got %b want 0", err); end
    finish_rsp();
  endtask

  task automatic test_partial_store();
    logic rdy, err; int lat; logic [31:0] rd;
    do_txn(1'b1, 32'h20, 32'h11223344, 4'hF, rdy, lat, rd, err); finish_rsp();
    do_txn(1'b1, 32'h20, 32'h0000AA00, 4'b0010, rdy, lat, rd, err); finish_rsp();
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, rdy, lat, rd, err);
    n_tests++; if (rd !== 32'h1122AA44) begin n_fail++; $display("FAIL ps_rdata: got %h want 1122aa44", rd); end
    finish_rsp();
    do_txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rdy, lat, rd, err);
    n_tests++; if (err !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL ps_nostrb_rsp: got err=%b rdata=%h want err=0 rdata=0", err, rd); end
    finish_rsp();
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, rdy, lat, rd, err);
    n_tests++; if (rd !== 32'h1122AA44) begin n_fail++; $display("FAIL ps_nostrb_keep: got %h want 1122aa44", rd); end
    finish_rsp();
  endtask

  task automatic test_faults();
    logic rdy, err; int lat; logic [31:0] rd;
    do_txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rdy, lat, rd, err); finish_rsp();
    do_txn(1'b1, 32'hFFC, 32'h13579BDF, 4'hF, rdy, lat, rd, err); finish_rsp();
    do_txn(1'b0, 32'h22, 32'h0, 4'h0, rdy, lat, rd, err);
    n_tests++; if (err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL flt_misalign: got err=%b rdata=%h want err=1 rdata=0", err, rd); end
    finish_rsp();
    do_txn(1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, rdy, lat, rd, err);
    n_tests++; if (err !== 1'b1 || lat != 3) begin n_fail++; $display("FAIL flt_range_store: got err=%b lat=%0d want err=1 lat=3", err, lat); end
    finish_rsp();
    do_txn(1'b0, 32'h0, 32'h0, 4'h0, rdy, lat, rd, err);
    n_tests++; if (err !== 1'b0 || rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL flt_word0_kept: got err=%b rdata=%h want err=0 rdata=cafef00d", err, rd); end
    finish_rsp();
    do_txn(1'b0, 32'hFFC, 32'h0, 4'h0, rdy, lat, rd, err);
    n_tests++; if (err !== 1'b0 || rd !== 32'h13579BDF) begin n_fail++; $display("FAIL flt_last_word: got err=%b rdata=%h want err=0 rdata=13579bdf", err, rd); end
    finish_rsp();
    do_txn(1'b0, 32'h1000, 32'h0, 4'h0, rdy, lat, rd, err);
    n_tests++; if (err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL flt_range_load: got err=%b rdata=%h want err=1 rdata=0", err, rd); end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    logic rdy, err; int lat; logic [31:0] rd;
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rdy, lat, rd, err);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got valid=%b rdata=%h err=%b req_ready=%b want 1/deadbeef/0/0",
                 c, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
    end
    finish_rsp();
    n_tests++;
    if (dbg_state !== ST_IDLE || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got state=%0d valid=%b req_ready=%b want IDLE/0/1", dbg_state, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic rdy, err; int lat; logic [31:0] rd;
    do_txn(1'b1, 32'h40, 32'h12345678, 4'hF, rdy, lat, rd, err); finish_rsp();
    send_req(1'b1, 32'h40, 32'h00000055, 4'hF, rdy);
    #1;
    n_tests++; if (dbg_state !== ST_WAIT) begin n_fail++; $display("FAIL rm_in_wait: got %0d want WAIT", dbg_state); end
    rst = 1'b0;
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || dbg_state !== ST_IDLE || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_async: got valid=%b req_ready=%b state=%0d err=%b want 0/0/IDLE/0",
               rsp_valid, req_ready, dbg_state, rsp_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_release_ready: got %b want 1", req_ready); end
    do_txn(1'b0, 32'h40, 32'h0, 4'h0, rdy, lat, rd, err);
    n_tests++; if (rd !== 32'h12345678 || err !== 1'b0) begin n_fail++; $display("FAIL rm_word_kept: got rdata=%h err=%b want 12345678/0", rd, err); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int t;
    logic [31:0] exp_rd;
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      t = e / 2;
      b_req_valid = 1'b1;
      b_req_we    = (t < 4);
      b_req_addr  = 32'h80 + 32'(4 * (t % 4));
      b_req_wdata = 32'hA000_0000 + 32'(t);
      b_req_wstrb = 4'hF;
      n_tests++;
      if (b_req_ready !== ((e % 2) == 0)) begin
        n_fail++; $display("FAIL b2b_ready_e%0d: got %b want %b", e, b_req_ready, (e % 2) == 0);
      end
      @(posedge clk); #1;
      n_tests++;
      if (b_rsp_valid !== ((e % 2) == 0)) begin
        n_fail++; $display("FAIL b2b_valid_e%0d: got %b want %b", e, b_rsp_valid, (e % 2) == 0);
      end
      if ((e % 2) == 0) begin
        exp_rd = (t >= 4) ? 32'hA000_0000 + 32'(t - 4) : 32'h0;
        n_tests++;
        if (b_rsp_rdata !== exp_rd || b_rsp_err !== 1'b0) begin
          n_fail++; $display("FAIL b2b_data_t%0d: got rdata=%h err=%b want %h/0", t, b_rsp_rdata, b_rsp_err, exp_rd);
        end
      end
    end
    @(negedge clk);
    b_req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_wstrb = '0;
    b_rsp_ready = 1'b1;

    test_reset();
    test_store_load();
    test_partial_store();
    test_faults();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
